// File: rtl/count_display_mux.sv
// count_display_mux: snapshots two 8-bit counts, converts each to 3-digit BCD with a
// serial double-dabble engine and scans them onto a 6-digit common-anode display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros in each 3-digit group.
module count_display_mux #(
  parameter int UPDATE_DIV = 32,
  parameter int SCAN_DIV   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] q0,
  input  logic [7:0] q1,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       busy,
  output logic       upd_done
);

  localparam int UW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [UW-1:0] UPD_LAST  = UW'(UPDATE_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV0, CONV1, LOAD} state_t;

  state_t        state, state_next;
  logic [UW-1:0] upd_cnt;
  logic          tick;
  logic [SW-1:0] scan_cnt;
  logic [2:0]    idx;
  logic [2:0]    step;
  logic          last_step;
  logic [7:0]    shadow0, shadow1;
  logic [11:0]   bcd, bcd_next, res0;
  logic [11:0]   disp0, disp1;
  logic [11:0]   grp;
  logic [1:0]    pos;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    seg_next;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next bit.
  function automatic logic [11:0] dd_step(input logic [11:0] b, input logic bit_in);
    logic [11:0] a;
    a = b;
    for (int i = 0; i < 3; i++)
      if (b[4*i +: 4] >= 4'd5) a[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return {a[10:0], bit_in};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign tick      = (upd_cnt == UPD_LAST);
  assign last_step = (step == 3'd7);
  assign busy      = (state != IDLE);
  assign bcd_next  = dd_step(bcd, (state == CONV1) ? shadow1[7] : shadow0[7]);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_cnt <= '0;
      state   <= IDLE;
    end else begin
      upd_cnt <= tick ? '0 : upd_cnt + 1'b1;
      state   <= state_next;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick) state_next = CONV0;
      CONV0:   if (last_step) state_next = CONV1;
      CONV1:   if (last_step) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: display registers are reset because an aborted update must leave zeros shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow0  <= '0;
      shadow1  <= '0;
      bcd      <= '0;
      step     <= '0;
      res0     <= '0;
      disp0    <= '0;
      disp1    <= '0;
      upd_done <= 1'b0;
    end else begin
      upd_done <= 1'b0;
      case (state)
        IDLE: if (tick) begin
          shadow0 <= q0;
          shadow1 <= q1;
          bcd     <= '0;
          step    <= '0;
        end
        CONV0: begin
          bcd     <= bcd_next;
          shadow0 <= {shadow0[6:0], 1'b0};
          step    <= step + 3'd1;
          if (last_step) begin
            res0 <= bcd_next;
            bcd  <= '0;
          end
        end
        CONV1: begin
          bcd     <= bcd_next;
          shadow1 <= {shadow1[6:0], 1'b0};
          step    <= step + 3'd1;
        end
        LOAD: begin
          disp0    <= res0;
          disp1    <= bcd;
          upd_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    grp = disp0;
    pos = 2'd0;
    case (idx)
      3'd0:    begin grp = disp0; pos = 2'd0; end
      3'd1:    begin grp = disp0; pos = 2'd1; end
      3'd2:    begin grp = disp0; pos = 2'd2; end
      3'd3:    begin grp = disp1; pos = 2'd0; end
      3'd4:    begin grp = disp1; pos = 2'd1; end
      3'd5:    begin grp = disp1; pos = 2'd2; end
      default: ;
    endcase
    case (pos)
      2'd0:    nib = grp[3:0];
      2'd1:    nib = grp[7:4];
      default: nib = grp[11:8];
    endcase
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (pos == 2'd2 && grp[11:8] == 4'd0) blank = 1'b1;
    if (pos == 2'd1 && grp[11:4] == 8'd0) blank = 1'b1;
`endif
    seg_next = blank ? 7'h7F : seg_code(nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      seg      <= 7'h7F;
      an       <= 6'h3F;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      an  <= ~(6'b000001 << idx);
      seg <= seg_next;
    end
  end

endmodule
